// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-side signals exchanged between the datapath and the
// hazard controller. The datapath drives register indices and control bits
// and receives forwarding selects, stage enables and the perf counters.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] rs1_d;
  logic [REG_ADDR_W-1:0] rs2_d;
  logic [REG_ADDR_W-1:0] rs1_e;
  logic [REG_ADDR_W-1:0] rs2_e;
  logic [REG_ADDR_W-1:0] rd_e;
  logic [REG_ADDR_W-1:0] rd_m;
  logic [REG_ADDR_W-1:0] rd_w;
  logic                  reg_write_m;
  logic                  reg_write_w;
  logic                  mem_read_e;
  logic                  muldiv_e;
  logic                  branch_taken_e;
  logic                  jump_e;
  logic                  mem_stall;
  logic                  perf_clr;
  logic [1:0]            forward_a_e;
  logic [1:0]            forward_b_e;
  logic                  stall_f;
  logic                  stall_d;
  logic                  stall_e;
  logic                  stall_m;
  logic                  flush_d;
  logic                  flush_e;
  logic                  md_busy;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_cycles;

  // Datapath side
  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output reg_write_m, reg_write_w, mem_read_e, muldiv_e,
    output branch_taken_e, jump_e, mem_stall, perf_clr,
    input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, md_busy, stall_cycles, flush_cycles
  );

  // Hazard controller side
  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  reg_write_m, reg_write_w, mem_read_e, muldiv_e,
    input  branch_taken_e, jump_e, mem_stall, perf_clr,
    output forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, md_busy, stall_cycles, flush_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: operand forwarding, load-use
// bubbles, control-flush, multi-cycle mul/div occupancy of E, cache-miss
// freeze and saturating stall/flush cycle counters.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  // Counter must hold MD_LATENCY-2; keep at least one bit for short latencies.
  localparam int MD_CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
  localparam logic [MD_CNT_W-1:0] MD_LOAD =
    (MD_LATENCY > 1) ? MD_CNT_W'(MD_LATENCY - 2) : '0;
  localparam bit MD_MULTI = (MD_LATENCY > 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  md_state_t             state_reg, state_next;
  logic [MD_CNT_W-1:0]   md_cnt_reg, md_cnt_next;
  logic                  md_stall;

  logic                  redirect;
  logic                  lu;
  logic [REG_ADDR_W-1:0] rs_e [2];
  logic [1:0]            fwd_sel [2];
  logic                  stall_fd_raw;
  logic                  stall_e_raw;
  logic                  flush_d_raw;
  logic                  flush_e_raw;
  logic [1:0]            cnt_inc;
  logic [CNT_W-1:0]      cnt_val [2];

  assign rs_e[0] = bus.rs1_e;
  assign rs_e[1] = bus.rs2_e;

  // Per-operand forwarding select, the younger M result wins over W
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_sel[gi] =
        (bus.reg_write_m && (bus.rd_m != '0) && (bus.rd_m == rs_e[gi])) ? 2'b10 :
        (bus.reg_write_w && (bus.rd_w != '0) && (bus.rd_w == rs_e[gi])) ? 2'b01 :
                                                                          2'b00;
    end
  endgenerate

  assign redirect = bus.branch_taken_e | bus.jump_e;
  assign lu = bus.mem_read_e && (bus.rd_e != '0) &&
              ((bus.rd_e == bus.rs1_d) || (bus.rd_e == bus.rs2_d));

  // Mul/div occupancy state and down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      md_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      md_cnt_reg <= md_cnt_next;
    end
  end

  // Mul/div next state; a cache miss freezes progress but not the stall
  always_comb begin
    state_next  = state_reg;
    md_cnt_next = md_cnt_reg;
    md_stall    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.muldiv_e && MD_MULTI) begin
          md_stall = 1'b1;
          if (!bus.mem_stall) begin
            md_cnt_next = MD_LOAD;
            state_next  = BUSY;
          end
        end
      end
      BUSY: begin
        if (md_cnt_reg != '0) begin
          md_stall = 1'b1;
          if (!bus.mem_stall) md_cnt_next = md_cnt_reg - 1'b1;
        end else if (!bus.mem_stall) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign stall_e_raw  = bus.mem_stall | md_stall;
  assign stall_fd_raw = bus.mem_stall | md_stall | (lu & ~redirect);
  assign flush_d_raw  = redirect & ~bus.mem_stall;
  assign flush_e_raw  = (redirect | (lu & ~stall_e_raw)) & ~bus.mem_stall;

  // Output drive; everything is held low while reset is asserted
  always_comb begin
    bus.forward_a_e = 2'b00;
    bus.forward_b_e = 2'b00;
    bus.stall_f     = 1'b0;
    bus.stall_d     = 1'b0;
    bus.stall_e     = 1'b0;
    bus.stall_m     = 1'b0;
    bus.flush_d     = 1'b0;
    bus.flush_e     = 1'b0;
    bus.md_busy     = 1'b0;
    if (!rst) begin
      bus.forward_a_e = fwd_sel[0];
      bus.forward_b_e = fwd_sel[1];
      bus.stall_f     = stall_fd_raw;
      bus.stall_d     = stall_fd_raw;
      bus.stall_e     = stall_e_raw;
      bus.stall_m     = bus.mem_stall;
      bus.flush_d     = flush_d_raw;
      bus.flush_e     = flush_e_raw;
      bus.md_busy     = (state_reg == BUSY);
    end
  end

  // Counter 0 tracks stall_f cycles, counter 1 tracks flush_e cycles
  assign cnt_inc[0] = ~rst & stall_fd_raw;
  assign cnt_inc[1] = ~rst & flush_e_raw;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      // Saturating counter, clear takes priority over increment
      always_ff @(posedge clk) begin
        if (rst || bus.perf_clr) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != CNT_MAX)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign cnt_val[gi] = cnt_reg;
    end
  endgenerate

  assign bus.stall_cycles = cnt_val[0];
  assign bus.flush_cycles = cnt_val[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MD_LATENCY=4 and 4-bit counters, plus a
// second instance with MD_LATENCY=1 for the no-occupancy case.
module tb_hazard_ctrl;

  localparam int RW      = 5;
  localparam int CW      = 4;
  localparam int CNT_MAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_sc   = 0;
  int exp_fc   = 0;

  hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus  ();
  hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus1 ();

  hazard_ctrl #(.REG_ADDR_W(RW), .MD_LATENCY(4), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  hazard_ctrl #(.REG_ADDR_W(RW), .MD_LATENCY(1), .CNT_W(CW)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one clock; s/f are the hand-derived stall_f/flush_e levels of the
  // cycle just ending, used to track the expected counter values.
  task automatic tick(input bit s, input bit f);
    @(posedge clk);
    if (s && exp_sc < CNT_MAX) exp_sc++;
    if (f && exp_fc < CNT_MAX) exp_fc++;
    #1;
  endtask

  task automatic idle_inputs();
    bus.rs1_d = '0; bus.rs2_d = '0; bus.rs1_e = '0; bus.rs2_e = '0;
    bus.rd_e = '0; bus.rd_m = '0; bus.rd_w = '0;
    bus.reg_write_m = 1'b0; bus.reg_write_w = 1'b0; bus.mem_read_e = 1'b0;
    bus.muldiv_e = 1'b0; bus.branch_taken_e = 1'b0; bus.jump_e = 1'b0;
    bus.mem_stall = 1'b0; bus.perf_clr = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, " stall_cycles"}, 32'(bus.stall_cycles), 32'(exp_sc));
    check({tag, " flush_cycles"}, 32'(bus.flush_cycles), 32'(exp_fc));
  endtask

  initial begin
    idle_inputs();
    bus1.rs1_d = '0; bus1.rs2_d = '0; bus1.rs1_e = '0; bus1.rs2_e = '0;
    bus1.rd_e = '0; bus1.rd_m = '0; bus1.rd_w = '0;
    bus1.reg_write_m = 1'b0; bus1.reg_write_w = 1'b0; bus1.mem_read_e = 1'b0;
    bus1.muldiv_e = 1'b0; bus1.branch_taken_e = 1'b0; bus1.jump_e = 1'b0;
    bus1.mem_stall = 1'b0; bus1.perf_clr = 1'b0;

    // Reset: outputs must be low even with active inputs
    bus.mem_stall = 1'b1; bus.jump_e = 1'b1;
    bus.rd_m = 5'd5; bus.rs1_e = 5'd5; bus.reg_write_m = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst stall_f", 32'(bus.stall_f), 32'd0);
    check("rst stall_m", 32'(bus.stall_m), 32'd0);
    check("rst flush_d", 32'(bus.flush_d), 32'd0);
    check("rst fwd_a", 32'(bus.forward_a_e), 32'd0);
    check("rst md_busy", 32'(bus.md_busy), 32'd0);
    rst = 1'b0;
    idle_inputs();
    #1;
    check_counters("after rst");

    // MD_LATENCY=1 never occupies E
    bus1.muldiv_e = 1'b1;
    #1;
    check("lat1 stall_e c1", 32'(bus1.stall_e), 32'd0);
    tick(0, 0);
    check("lat1 md_busy c2", 32'(bus1.md_busy), 32'd0);
    check("lat1 stall_f c2", 32'(bus1.stall_f), 32'd0);
    bus1.muldiv_e = 1'b0;

    // Forwarding priority
    bus.rd_m = 5'd5; bus.rd_w = 5'd5; bus.rs1_e = 5'd5;
    bus.reg_write_m = 1'b1; bus.reg_write_w = 1'b1;
    #1;
    check("fwd_a M over W", 32'(bus.forward_a_e), 32'h2);
    bus.reg_write_m = 1'b0;
    #1;
    check("fwd_a W", 32'(bus.forward_a_e), 32'h1);
    bus.rs2_e = 5'd7; bus.rd_m = 5'd7; bus.reg_write_m = 1'b1;
    #1;
    check("fwd_b M", 32'(bus.forward_b_e), 32'h2);
    check("fwd_a W still", 32'(bus.forward_a_e), 32'h1);
    bus.rs1_e = '0; bus.rs2_e = '0; bus.rd_m = '0; bus.rd_w = '0;
    #1;
    check("fwd_a x0", 32'(bus.forward_a_e), 32'h0);
    check("fwd_b x0", 32'(bus.forward_b_e), 32'h0);
    idle_inputs();

    // Load-use
    bus.mem_read_e = 1'b1; bus.rd_e = 5'd3; bus.rs2_d = 5'd3;
    #1;
    check("lu stall_f", 32'(bus.stall_f), 32'd1);
    check("lu stall_d", 32'(bus.stall_d), 32'd1);
    check("lu flush_e", 32'(bus.flush_e), 32'd1);
    check("lu stall_e", 32'(bus.stall_e), 32'd0);
    check("lu flush_d", 32'(bus.flush_d), 32'd0);
    tick(1, 1);
    check_counters("lu");
    bus.rd_e = '0; bus.rs2_d = '0;
    #1;
    check("lu x0 stall_f", 32'(bus.stall_f), 32'd0);
    check("lu x0 flush_e", 32'(bus.flush_e), 32'd0);

    // Load-use coinciding with a jump: flush wins
    bus.rd_e = 5'd3; bus.rs1_d = 5'd3; bus.jump_e = 1'b1;
    #1;
    check("lu+jump stall_f", 32'(bus.stall_f), 32'd0);
    check("lu+jump flush_d", 32'(bus.flush_d), 32'd1);
    check("lu+jump flush_e", 32'(bus.flush_e), 32'd1);
    tick(0, 1);
    check_counters("lu+jump");
    idle_inputs();

    // Mul/div, MD_LATENCY=4, no miss
    for (int c = 1; c <= 4; c++) begin
      bus.muldiv_e = 1'b1;
      #1;
      check($sformatf("md c%0d stall_e", c), 32'(bus.stall_e), 32'(c <= 3));
      check($sformatf("md c%0d stall_f", c), 32'(bus.stall_f), 32'(c <= 3));
      check($sformatf("md c%0d md_busy", c), 32'(bus.md_busy), 32'(c >= 2));
      tick(c <= 3, 0);
    end
    bus.muldiv_e = 1'b0;
    #1;
    check("md c5 md_busy", 32'(bus.md_busy), 32'd0);
    check("md c5 stall_e", 32'(bus.stall_e), 32'd0);
    check_counters("md");

    // Mul/div with a 2-cycle miss during BUSY
    for (int c = 1; c <= 6; c++) begin
      bus.muldiv_e = 1'b1;
      bus.mem_stall = (c == 2 || c == 3);
      #1;
      check($sformatf("mdm c%0d stall_e", c), 32'(bus.stall_e), 32'(c <= 5));
      check($sformatf("mdm c%0d stall_m", c), 32'(bus.stall_m), 32'(c == 2 || c == 3));
      check($sformatf("mdm c%0d md_busy", c), 32'(bus.md_busy), 32'(c >= 2));
      check($sformatf("mdm c%0d flush", c), 32'({bus.flush_d, bus.flush_e}), 32'd0);
      tick(c <= 5, 0);
    end
    bus.muldiv_e = 1'b0; bus.mem_stall = 1'b0;
    #1;
    check("mdm c7 md_busy", 32'(bus.md_busy), 32'd0);
    check_counters("mdm");

    // Redirect held while frozen, applied once the miss clears
    bus.jump_e = 1'b1; bus.mem_stall = 1'b1;
    #1;
    check("jmp miss flush_d", 32'(bus.flush_d), 32'd0);
    check("jmp miss flush_e", 32'(bus.flush_e), 32'd0);
    check("jmp miss stall_f", 32'(bus.stall_f), 32'd1);
    tick(1, 0);
    bus.mem_stall = 1'b0;
    #1;
    check("jmp free flush_d", 32'(bus.flush_d), 32'd1);
    check("jmp free flush_e", 32'(bus.flush_e), 32'd1);
    check("jmp free stall_f", 32'(bus.stall_f), 32'd0);
    tick(0, 1);
    check_counters("jmp");
    idle_inputs();

    // Saturation of the stall counter
    bus.mem_stall = 1'b1;
    for (int c = 0; c < 8; c++) tick(1, 0);
    check("sat stall_cycles", 32'(bus.stall_cycles), 32'd15);
    check_counters("sat");

    // Clear beats increment
    bus.perf_clr = 1'b1;
    @(posedge clk);
    exp_sc = 0; exp_fc = 0;
    #1;
    check_counters("clr");
    idle_inputs();

    // Reset in the middle of BUSY
    bus.muldiv_e = 1'b1;
    tick(1, 0);
    tick(1, 0);
    check("pre-rst md_busy", 32'(bus.md_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("in-rst stall_e", 32'(bus.stall_e), 32'd0);
    check("in-rst md_busy", 32'(bus.md_busy), 32'd0);
    @(posedge clk);
    exp_sc = 0; exp_fc = 0;
    #1;
    rst = 1'b0;
    bus.muldiv_e = 1'b0;
    #1;
    check("post-rst md_busy", 32'(bus.md_busy), 32'd0);
    check("post-rst stall_f", 32'(bus.stall_f), 32'd0);
    check_counters("post-rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the 5-stage pipeline. It adds the following on top of combinational forwarding, load-use and control-flush logic:
- a multi-cycle mul/div occupancy FSM that holds E for `MD_LATENCY` cycles;
- cache-miss freeze of every stage;
- saturating performance counters for stall and flush cycles.

It sits beside the datapath, takes register indices and control bits from D/E/M/W, and drives stage-enable and flush lines.

## Interface
Parameters:
- `REG_ADDR_W`, 5, register index width; index 0 is the hardwired zero register.
- `MD_LATENCY`, 4, E-stage occupancy in cycles of a mul/div instruction; must be ≥1.
- `CNT_W`, 16, width of each performance counter.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rs1_d`, `rs2_d` in `REG_ADDR_W`: D-stage source registers.
- `rs1_e`, `rs2_e`, `rd_e` in `REG_ADDR_W`: E-stage sources and destination.
- `rd_m`, `rd_w` in `REG_ADDR_W`: M- and W-stage destinations.
- `reg_write_m`, `reg_write_w` in 1: register write enables for M and W.
- `mem_read_e` in 1: the E instruction is a load.
- `muldiv_e` in 1: the E instruction is mul/div.
- `branch_taken_e`, `jump_e` in 1: redirect resolved in E.
- `mem_stall` in 1: the cache is not ready and the whole pipeline must freeze.
- `perf_clr` in 1: synchronous clear of both counters.
- `forward_a_e`, `forward_b_e` out 2: operand mux select. 00 = register file, 10 = M result, 01 = W result.
- `stall_f`, `stall_d`, `stall_e`, `stall_m` out 1: hold the PC and the D/E/M pipeline registers.
- `flush_d`, `flush_e` out 1: bubble the D and E registers.
- `md_busy` out 1: the mul/div FSM is in BUSY.
- `stall_cycles` out `CNT_W`: count of cycles with `stall_f`=1.
- `flush_cycles` out `CNT_W`: count of cycles with `flush_e`=1.

## Operation
**Forwarding**, per operand `x` in {1, 2}:
- If `reg_write_m` && `rd_m`≠0 && `rd_m`==`rs{x}_e`, select 10.
- Otherwise, if `reg_write_w` && `rd_w`≠0 && `rd_w`==`rs{x}_e`, select 01.
- Otherwise select 00.
- M has priority over W.
- Forwarding is unaffected by stalls.

**Load-use:**
- `lu` = `mem_read_e` && `rd_e`≠0 && (`rd_e`==`rs1_d` || `rd_e`==`rs2_d`).
- Result: `stall_f`=`stall_d`=1 and `flush_e`=1.

**Mul/div FSM**, states IDLE and BUSY, with a down-counter `md_cnt`:
- IDLE with `muldiv_e`=1 and `MD_LATENCY`>1 (mem_stall does not gate this stall): `stall_f`=`stall_d`=`stall_e`=1.
  - If `mem_stall`=0: `md_cnt`←`MD_LATENCY`−2 and go to BUSY.
  - If `mem_stall`=1: the FSM stays in IDLE.
- BUSY with `md_cnt`≠0: stall F/D/E. When `mem_stall`=0, decrement `md_cnt`; when `mem_stall`=1, hold it.
- BUSY with `md_cnt`==0: no mul/div stall this cycle. Return to IDLE when `mem_stall`=0, so the instruction leaves E.
- `MD_LATENCY`==1: the FSM never leaves IDLE and never stalls.
- A back-to-back mul/div re-triggers from IDLE.
- `md_busy` = (state==BUSY).

**Control flush:**
- When `branch_taken_e` || `jump_e`: `flush_d`=`flush_e`=1.
- Flush overrides the load-use stall, forcing `stall_f`=`stall_d`=0 from the load-use source.
- `muldiv_e` and a redirect never coincide; behaviour in that case is unspecified.

**Memory freeze:**
- `mem_stall`=1 forces all four stall outputs to 1 and both flush outputs to 0.
- A pending redirect or load-use bubble is applied on the first cycle after `mem_stall` falls, because E is frozen and its inputs persist.

**Output composition:**
- `stall_f`, `stall_d`: OR of `mem_stall`, mul/div stall, and (`lu` && !redirect).
- `stall_e`: `mem_stall` || mul/div stall.
- `stall_m`: `mem_stall`.
- `flush_d`: redirect && !`mem_stall`.
- `flush_e`: (redirect || (`lu` && !`stall_e`)) && !`mem_stall`.

**Counters:**
- Each counter increments by 1 on every cycle its qualifying output is 1.
- Both saturate at 2^`CNT_W`−1.
- `perf_clr` zeroes both and has priority over increment.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and FSM state, with zero-cycle latency.
- The FSM and counters update on the `clk` rising edge.
- A counter reflects a cycle's event on the next cycle.
- While `rst`=1, all outputs are driven to 0 (forward selects 00, stalls 0, flushes 0, `md_busy` 0).
- Registered reset values: state IDLE, `md_cnt`=0, `stall_cycles`=0, `flush_cycles`=0.
- Reset asserted while BUSY aborts the sequence. The next cycle is IDLE with no stall.
- Mul/div occupancy: with `MD_LATENCY`=N and no `mem_stall`, E is held for N−1 stalled cycles and advances at the end of cycle N.

## Test plan
- **Forwarding priority:** `rd_m`=`rd_w`=`rs1_e`=5, both write enables 1 → `forward_a_e`=10. Then `reg_write_m`=0 → 01. Then `rs1_e`=`rd_m`=`rd_w`=0 → 00.
- **Load-use:** `mem_read_e`=1, `rd_e`=3, `rs2_d`=3 → `stall_f`=`stall_d`=`flush_e`=1, `stall_e`=0, `stall_cycles` +1 next cycle. With `rd_e`=0 → no stall.
- **Mul/div, `MD_LATENCY`=4:** hold `muldiv_e`=1 → stall F/D/E for exactly 3 cycles, `md_busy` 1 for cycles 2–4, stall 0 in cycle 4, IDLE in cycle 5.
- **Mul/div under cache miss:** repeat the mul/div case with `mem_stall`=1 for 2 cycles during BUSY → total stall lengthens by 2, and `flush_d`/`flush_e` stay 0.
- **Redirect during miss:** `jump_e`=1 with `mem_stall`=1 → no flush while frozen. `mem_stall`→0 → `flush_d`=`flush_e`=1 that cycle, and `flush_cycles` increments by 1 only.
- **Counters and reset:** preload `stall_cycles` near 2^`CNT_W`−1 (`CNT_W`=4) → saturates at 15. `perf_clr`=1 → 0. `rst` mid-BUSY → next cycle IDLE, all outputs 0.
